// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle control unit:
// states, opcodes, functs, aluop and ALU control codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECUTE,
    ALUWB,
    BRANCH,
    ADDIEXEC,
    ADDIWB,
    JUMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] AC_AND = 3'b000;
  localparam logic [2:0] AC_OR  = 3'b001;
  localparam logic [2:0] AC_ADD = 3'b010;
  localparam logic [2:0] AC_SUB = 3'b110;
  localparam logic [2:0] AC_SLT = 3'b111;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields
// and flag in, datapath control strobes out.
interface multicycle_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic       pcen;
  logic [2:0] alucontrol;
  logic       illegal;

  modport master (
    input  op, funct, zero,
    output iord, memwrite, irwrite, regdst,
    output memtoreg, regwrite, alusrca, alusrcb,
    output pcsrc, pcen, alucontrol, illegal
  );

  modport slave (
    output op, funct, zero,
    input  iord, memwrite, irwrite, regdst,
    input  memtoreg, regwrite, alusrca, alusrcb,
    input  pcsrc, pcen, alucontrol, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps aluop (and funct for R-type) to the ALU
// control code; flags functs the ALU cannot run.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       bad_funct
);

  always_comb begin
    alucontrol = AC_ADD;
    bad_funct  = 1'b0;
    unique case (aluop)
      ALUOP_SUB: alucontrol = AC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = AC_ADD;
          FN_SUB:  alucontrol = AC_SUB;
          FN_AND:  alucontrol = AC_AND;
          FN_OR:   alucontrol = AC_OR;
          FN_SLT:  alucontrol = AC_SLT;
          default: bad_funct  = 1'b1;
        endcase
      end
      default: alucontrol = AC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS-style
// datapath; only pcen looks at the live zero flag.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic clk,
  input  logic reset,
  multicycle_controller_if.master bus
);

  state_t state, next, cs;
  aluop_t aluop;
  logic   pcwrite, branch, bad_op, bad_funct;
  logic   irwrite, memwrite, regwrite;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  // During reset the outputs look like FETCH with
  // every write strobe suppressed below.
  assign cs = reset ? FETCH : state;

  always_comb begin
    next         = FETCH;
    aluop        = ALUOP_ADD;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    bad_op       = 1'b0;
    irwrite      = 1'b0;
    memwrite     = 1'b0;
    regwrite     = 1'b0;
    bus.iord     = 1'b0;
    bus.regdst   = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    unique case (cs)
      FETCH: begin
        bus.alusrcb = 2'b01;
        irwrite     = 1'b1;
        pcwrite     = 1'b1;
        next        = DECODE;
      end
      DECODE: begin
        bus.alusrcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: next = MEMADR;
          OP_RTYPE:     next = EXECUTE;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEXEC;
          OP_J:         next = JUMP;
          default:      bad_op = 1'b1;
        endcase
      end
      MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next = (bus.op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.iord = 1'b1;
        next     = MEMWB;
      end
      MEMWB: begin
        bus.memtoreg = 1'b1;
        regwrite     = 1'b1;
      end
      MEMWR: begin
        bus.iord = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_FUNCT;
        next        = ALUWB;
      end
      ALUWB: begin
        bus.regdst = 1'b1;
        regwrite   = 1'b1;
      end
      BRANCH: begin
        bus.alusrca = 1'b1;
        aluop       = ALUOP_SUB;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
      end
      ADDIEXEC: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        next        = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JUMP: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol),
    .bad_funct  (bad_funct)
  );

  assign bus.irwrite  = irwrite & ~reset;
  assign bus.memwrite = memwrite & ~reset;
  assign bus.regwrite = regwrite & ~reset;
  assign bus.pcen     = (pcwrite | (branch & bus.zero)) & ~reset;
  assign bus.illegal  = (bad_op | bad_funct) & ~reset;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: per-cycle expected control words
// from an instruction-level model, checked by a monitor.
module tb_multicycle_controller;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] aluc;
    logic       illegal;
  } ov_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  ov_t   exp_q[$];
  string name_q[$];
  int    nvec = 0;
  int    nerr = 0;

  function automatic bit legal_op(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000000 || op == 6'b000100 ||
           op == 6'b001000 || op == 6'b000010;
  endfunction

  function automatic int plen(logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return 4;
      6'b001000: return 4;
      6'b000100: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  function automatic string phase(logic [5:0] op, int k);
    if (k == 0) return "FETCH";
    if (k == 1) return "DECODE";
    case (op)
      6'b100011: return k == 2 ? "MEMADR" : (k == 3 ? "MEMRD" : "MEMWB");
      6'b101011: return k == 2 ? "MEMADR" : "MEMWR";
      6'b000000: return k == 2 ? "EXECUTE" : "ALUWB";
      6'b001000: return k == 2 ? "ADDIEXEC" : "ADDIWB";
      6'b000100: return "BRANCH";
      default:   return "JUMP";
    endcase
  endfunction

  function automatic ov_t model(string ph, logic rst, logic z,
                                logic [5:0] op, logic [5:0] fn);
    ov_t v;
    v = '0;
    v.aluc = 3'b010;
    if (rst) begin
      v.alusrcb = 2'b01;
      return v;
    end
    case (ph)
      "FETCH": begin
        v.alusrcb = 2'b01; v.irwrite = 1; v.pcen = 1;
      end
      "DECODE": begin
        v.alusrcb = 2'b11; v.illegal = !legal_op(op);
      end
      "MEMADR", "ADDIEXEC": begin
        v.alusrca = 1; v.alusrcb = 2'b10;
      end
      "MEMRD": v.iord = 1;
      "MEMWB": begin
        v.memtoreg = 1; v.regwrite = 1;
      end
      "MEMWR": begin
        v.iord = 1; v.memwrite = 1;
      end
      "EXECUTE": begin
        v.alusrca = 1;
        case (fn)
          6'b100000: v.aluc = 3'b010;
          6'b100010: v.aluc = 3'b110;
          6'b100100: v.aluc = 3'b000;
          6'b100101: v.aluc = 3'b001;
          6'b101010: v.aluc = 3'b111;
          default:   v.illegal = 1;
        endcase
      end
      "ALUWB": begin
        v.regdst = 1; v.regwrite = 1;
      end
      "ADDIWB": v.regwrite = 1;
      "BRANCH": begin
        v.alusrca = 1; v.aluc = 3'b110;
        v.pcsrc = 2'b01; v.pcen = z;
      end
      "JUMP": begin
        v.pcsrc = 2'b10; v.pcen = 1;
      end
      default: ;
    endcase
    return v;
  endfunction

  // Drive one instruction; abort_at >= 1 asserts reset in that cycle.
  // zsel < 0 randomizes zero every cycle.
  task automatic run_instr(logic [5:0] op, logic [5:0] fn,
                           int zsel, int abort_at);
    string ph;
    logic z;
    for (int k = 0; k < plen(op); k++) begin
      @(posedge clk); #1;
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      bus.op = op;
      bus.funct = fn;
      bus.zero = z;
      ph = phase(op, k);
      if (k == abort_at) begin
        reset = 1'b1;
        exp_q.push_back(model(ph, 1'b1, z, op, fn));
        name_q.push_back({ph, "/reset"});
        return;
      end
      reset = 1'b0;
      exp_q.push_back(model(ph, 1'b0, z, op, fn));
      name_q.push_back(ph);
    end
  endtask

  always @(negedge clk) begin
    ov_t a, e;
    string nm;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      a = '{bus.iord, bus.memwrite, bus.irwrite, bus.regdst,
            bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb,
            bus.pcsrc, bus.pcen, bus.alucontrol, bus.illegal};
      nvec++;
      if (a !== e) begin
        nerr++;
        $display("FAIL %s t=%0t op=%b fn=%b got=%h exp=%h", nm,
                 $time, bus.op, bus.funct, a, e);
      end
    end
  end

  logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000,
                               6'b000100, 6'b001000, 6'b000010};
  logic [5:0] legal_fns[5] = '{6'b100000, 6'b100010, 6'b100100,
                               6'b100101, 6'b101010};

  initial begin
    logic [5:0] op, fn;
    int ab;
    bus.op = 6'b100011;
    bus.funct = 6'b100000;
    bus.zero = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(model("FETCH", 1'b1, 1'b0, 6'b0, 6'b0));
    name_q.push_back("reset");
    @(posedge clk); #1;
    exp_q.push_back(model("FETCH", 1'b1, 1'b0, 6'b0, 6'b0));
    name_q.push_back("reset2");

    run_instr(6'b100011, 6'b100000, -1, -1);
    run_instr(6'b000100, 6'b000000, 1, -1);
    run_instr(6'b000100, 6'b000000, 0, -1);
    run_instr(6'b000000, 6'b101010, -1, -1);
    run_instr(6'b000000, 6'b111111, -1, -1);
    run_instr(6'b111111, 6'b000000, -1, -1);
    run_instr(6'b101011, 6'b000000, -1, 3);
    run_instr(6'b101011, 6'b000000, -1, -1);
    run_instr(6'b001000, 6'b000000, -1, -1);
    run_instr(6'b000010, 6'b000000, -1, -1);
    run_instr(6'b000000, 6'b100010, -1, 1);
    run_instr(6'b100011, 6'b000000, -1, 4);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) < 6)
        op = legal_ops[$urandom_range(0, 5)];
      else
        op = 6'($urandom);
      if ($urandom_range(0, 3) != 0)
        fn = legal_fns[$urandom_range(0, 4)];
      else
        fn = 6'($urandom);
      ab = -1;
      if ($urandom_range(0, 7) == 0)
        ab = $urandom_range(1, plen(op) - 1);
      run_instr(op, fn, -1, ab);
    end

    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none; all encodings fixed in the shared package.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 op  in  6  instruction opcode from the instruction register, bits [31:26].
REQ-005 funct  in  6  R-type function field, bits [5:0].
REQ-006 zero  in  1  ALU zero flag from the current cycle.
REQ-007 iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-008 memwrite  out  1  data memory write enable.
REQ-009 irwrite  out  1  instruction register load enable.
REQ-010 regdst  out  1  register write address select: 0 = rt, 1 = rd.
REQ-011 memtoreg  out  1  register write data select: 0 = ALUOut, 1 = Data.
REQ-012 regwrite  out  1  register file write enable.
REQ-013 alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
REQ-014 alusrcb  out  2  ALU B select: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
REQ-015 pcsrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
REQ-016 pcen  out  1  PC load enable.
REQ-017 alucontrol  out  3  ALU operation code.
REQ-018 illegal  out  1  one-cycle pulse on an unsupported opcode or funct.

Function
REQ-019 Moore FSM; all outputs except pcen decode from the current state alone.
REQ-020 pcen = pcwrite OR (branch AND zero), where pcwrite and branch are internal state-decoded signals.
REQ-021 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-022 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00, irwrite=1, pcwrite=1; next state DECODE.
REQ-023 DECODE: alusrca=0, alusrcb=11, aluop=ADD. Next state by op:
- lw (100011) or sw (101011) -> MEMADR
- R-type (000000) -> EXECUTE
- beq (000100) -> BRANCH
- addi (001000) -> ADDIEXEC
- j (000010) -> JUMP
- any other op -> FETCH, with illegal=1 for that cycle.
REQ-024 MEMADR: alusrca=1, alusrcb=10, aluop=ADD; next MEMRD for lw, MEMWR for sw.
REQ-025 MEMRD: iord=1; next MEMWB.
REQ-026 MEMWB: regdst=0, memtoreg=1, regwrite=1; next FETCH.
REQ-027 MEMWR: iord=1, memwrite=1; next FETCH.
REQ-028 EXECUTE: alusrca=1, alusrcb=00, aluop=FUNCT; next ALUWB.
REQ-029 ALUWB: regdst=1, memtoreg=0, regwrite=1; next FETCH.
REQ-030 BRANCH: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1; next FETCH.
REQ-031 ADDIEXEC: alusrca=1, alusrcb=10, aluop=ADD; next ADDIWB.
REQ-032 ADDIWB: regdst=0, memtoreg=0, regwrite=1; next FETCH.
REQ-033 JUMP: pcsrc=10, pcwrite=1; next FETCH.
REQ-034 Signals not listed for a state are 0.
REQ-035 Cycle counts FETCH->FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
REQ-036 ALU decode: ADD -> 010, SUB -> 110.
REQ-037 ALU decode for FUNCT: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
REQ-038 Any other funct in EXECUTE -> alucontrol 010, illegal=1 for that cycle, ALUWB still executes.

Reset
REQ-039 reset high at a clock edge loads state FETCH; no other storage exists.
REQ-040 While reset is high, pcen, irwrite, memwrite, regwrite and illegal are forced 0; other outputs follow FETCH values.
REQ-041 reset asserted in any state, mid-instruction included, aborts the instruction; the first cycle after reset deasserts is FETCH.

Structure
REQ-042 Shared package holds: state enumeration, opcode constants, funct constants, the aluop encoding (ADD/SUB/FUNCT, 2 bits) and alucontrol codes.
REQ-043 One sub-module, alu_decoder (aluop, funct -> alucontrol, bad_funct), is instantiated once.

Verification
REQ-044 Release reset, op=100011 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-045 op=000100, zero=1 in BRANCH -> pcen=1 and pcsrc=01 in cycle 3; repeat with zero=0 -> pcen=0 in cycle 3.
REQ-046 op=000000, funct=101010 -> alucontrol=111 in EXECUTE; funct=111111 -> illegal pulses for 1 cycle, alucontrol=010.
REQ-047 op=111111 -> illegal=1 in DECODE, FETCH on the next cycle, no regwrite or memwrite asserted.
REQ-048 reset asserted during MEMWR -> memwrite=0 that cycle, state FETCH after deassert, irwrite=1 on the first post-reset cycle.
REQ-049 Sequence sw, addi, j -> FETCH-to-FETCH cycle counts 4, 4, 3 respectively.
